// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MEM-stage data-memory stall controller.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        ERROR
    } dmem_state_t;

    localparam int DMEM_TIMEOUT = 255;

endpackage

// File: rtl/dmem_stall_ctrl_if.sv
// Data-memory request/ready port between the MEM-stage controller and the memory.
interface dmem_stall_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_stall_ctrl_wait_timer.sv
// Wait-cycle counter for an outstanding memory access; tc flags the last allowed cycle.
module dmem_stall_ctrl_wait_timer #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Holds at the terminal value so it can never wrap, even if en stays high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/dmem_stall_ctrl.sv
// MEM-stage data-memory sequencer: holds F/D/E/M and bubbles MEM/WB while an access is outstanding.
// Optional stall-cycle performance counter enabled by defining DMEM_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | no access outstanding; an access here stalls and launches ACCESS
// ACCESS | request driven to memory, waiting for mem_ready
// DONE   | release cycle; pipeline advances and MEM/WB latches ReadDataM
// ERROR  | memory timed out; pipeline frozen until reset
module dmem_stall_ctrl
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT,
    parameter int CNT_W          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      MemReadM,
    input  logic                      MemWriteM,
    dmem_stall_ctrl_if.master         mem,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      BubbleW,
    output logic [31:0]               ReadDataM,
    output logic                      MemErr,
    output logic [31:0]               StallCount
);

    dmem_state_t state;
    dmem_state_t state_nxt;

    logic access;
    logic is_load;
    logic stall;
    logic req;
    logic we;
    logic err;
    logic capture;
    logic tmr_clr;
    logic tmr_en;
    logic tmr_tc;

    assign access  = MemReadM | MemWriteM;
    // A simultaneous read and write is treated as a store.
    assign is_load = MemReadM & ~MemWriteM;

    dmem_stall_ctrl_wait_timer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        req       = 1'b0;
        we        = 1'b0;
        err       = 1'b0;
        capture   = 1'b0;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    stall     = 1'b1;
                    tmr_clr   = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                req   = 1'b1;
                we    = MemWriteM;
                // A response on the timeout cycle still completes normally.
                if (mem.mem_ready) begin
                    capture   = is_load;
                    state_nxt = DONE;
                end else if (tmr_tc) begin
                    state_nxt = ERROR;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            ERROR: begin
                stall = 1'b1;
                err   = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ReadDataM <= '0;
        end else if (capture) begin
            ReadDataM <= mem.mem_rdata;
        end
    end

    assign mem.mem_req = req;
    assign mem.mem_we  = we;
    assign StallF      = stall;
    assign StallD      = stall;
    assign StallE      = stall;
    assign StallM      = stall;
    assign BubbleW     = stall;
    assign MemErr      = err;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign StallCount = stall_cnt;
`else
    assign StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed bench for dmem_stall_ctrl with a small timeout so the ERROR path is reachable.
module tb_dmem_stall_ctrl;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic        StallF, StallD, StallE, StallM, BubbleW;
    logic [31:0] ReadDataM;
    logic        MemErr;
    logic [31:0] StallCount;

    dmem_stall_ctrl_if mif ();

    dmem_stall_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .mem        (mif),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .BubbleW    (BubbleW),
        .ReadDataM  (ReadDataM),
        .MemErr     (MemErr),
        .StallCount (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        logic  stall;
        logic  req;
        logic  we;
        logic  err;
        bit    rel;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] rdq[$];
    logic [31:0] exp_rd;
    int          n_assert;
    int          n_fail;

`ifdef DMEM_PERF_CNT_EN
    localparam logic [31:0] STORE_STALLS = 32'd5;
`else
    localparam logic [31:0] STORE_STALLS = 32'd0;
`endif

    // One clock of stimulus; expected outputs are queued on drive and popped at the sample point.
    task automatic cyc(input string tag, input logic rst, input logic rd, input logic wr,
                       input logic rdy, input logic [31:0] rdata,
                       input logic e_stall, input logic e_req, input logic e_we, input logic e_err,
                       input bit push_rd, input bit rel);
        exp_t e;
        reset         = rst;
        MemReadM      = rd;
        MemWriteM     = wr;
        mif.mem_ready = rdy;
        mif.mem_rdata = rdata;
        if (push_rd) rdq.push_back(rdata);
        expq.push_back('{tag: tag, stall: e_stall, req: e_req, we: e_we, err: e_err, rel: rel});
        @(negedge clk);
        e = expq.pop_front();
        if (e.rel && rdq.size() != 0) exp_rd = rdq.pop_front();

        n_assert++;
        assert ({StallF, StallD, StallE, StallM, BubbleW} === {5{e.stall}}) else begin
            n_fail++;
            $error("FAIL %s stall/bubble: observed %b expected %b", e.tag,
                   {StallF, StallD, StallE, StallM, BubbleW}, {5{e.stall}});
        end
        n_assert++;
        assert (mif.mem_req === e.req) else begin
            n_fail++;
            $error("FAIL %s mem_req: observed %b expected %b", e.tag, mif.mem_req, e.req);
        end
        n_assert++;
        assert (mif.mem_we === e.we) else begin
            n_fail++;
            $error("FAIL %s mem_we: observed %b expected %b", e.tag, mif.mem_we, e.we);
        end
        n_assert++;
        assert (MemErr === e.err) else begin
            n_fail++;
            $error("FAIL %s MemErr: observed %b expected %b", e.tag, MemErr, e.err);
        end
        n_assert++;
        assert (ReadDataM === exp_rd) else begin
            n_fail++;
            $error("FAIL %s ReadDataM: observed %h expected %h", e.tag, ReadDataM, exp_rd);
        end

        if (!rst) begin
            exp_rd = 32'd0;
            rdq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] exp_cnt);
        n_assert++;
        assert (StallCount === exp_cnt) else begin
            n_fail++;
            $error("FAIL %s StallCount: observed %0d expected %0d", tag, StallCount, exp_cnt);
        end
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        exp_rd        = 32'd0;
        reset         = 1'b0;
        MemReadM      = 1'b0;
        MemWriteM     = 1'b0;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        // tag, rst, rd, wr, rdy, rdata, stall, req, we, err, push_rd, rel
        cyc("reset", 1, 0, 0, 0, 32'd0, 0, 0, 0, 0, 0, 0);
        chk_cnt("reset", 32'd0);

        // Store, ready on the 4th ACCESS cycle (also the timeout cycle).
        cyc("st_idle", 1, 0, 1, 0, 32'd0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("st_wait", 1, 0, 1, 0, 32'd0, 1, 1, 1, 0, 0, 0);
        cyc("st_rdy", 1, 0, 1, 1, 32'h1234_5678, 1, 1, 1, 0, 0, 0);
        cyc("st_done", 1, 0, 0, 0, 32'd0, 0, 0, 0, 0, 0, 1);
        chk_cnt("st_cnt", STORE_STALLS);

        cyc("idle_rdy", 1, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
        cyc("idle_chk", 1, 0, 0, 0, 32'd0, 0, 0, 0, 0, 0, 0);

        // Load, ready in the first ACCESS cycle.
        cyc("ld_idle", 1, 1, 0, 0, 32'd0, 1, 0, 0, 0, 0, 0);
        cyc("ld_acc", 1, 1, 0, 1, 32'hDEAD_BEEF, 1, 1, 0, 0, 1, 0);
        cyc("ld_done", 1, 0, 0, 0, 32'd0, 0, 0, 0, 0, 0, 1);
        cyc("ld_after", 1, 0, 0, 0, 32'd0, 0, 0, 0, 0, 0, 0);

        // Back-to-back loads; the first load is still visible during its DONE cycle.
        cyc("b2b_idle1", 1, 1, 0, 0, 32'd0, 1, 0, 0, 0, 0, 0);
        cyc("b2b_acc1", 1, 1, 0, 1, 32'h0000_0001, 1, 1, 0, 0, 1, 0);
        cyc("b2b_done1", 1, 1, 0, 0, 32'd0, 0, 0, 0, 0, 0, 1);
        cyc("b2b_idle2", 1, 1, 0, 0, 32'd0, 1, 0, 0, 0, 0, 0);
        cyc("b2b_acc2", 1, 1, 0, 1, 32'h0000_0002, 1, 1, 0, 0, 1, 0);
        cyc("b2b_done2", 1, 0, 0, 0, 32'd0, 0, 0, 0, 0, 0, 1);

        // Read and write together behave as a store: no capture.
        cyc("rw_idle", 1, 1, 1, 0, 32'd0, 1, 0, 0, 0, 0, 0);
        cyc("rw_acc", 1, 1, 1, 1, 32'hAAAA_5555, 1, 1, 1, 0, 0, 0);
        cyc("rw_done", 1, 0, 0, 0, 32'd0, 0, 0, 0, 0, 0, 1);

        // Reset in the 2nd ACCESS cycle, then a late ready pulse.
        cyc("ra_idle", 1, 1, 0, 0, 32'd0, 1, 0, 0, 0, 0, 0);
        cyc("ra_acc1", 1, 1, 0, 0, 32'd0, 1, 1, 0, 0, 0, 0);
        cyc("ra_acc2", 0, 1, 0, 0, 32'd0, 1, 1, 0, 0, 0, 0);
        cyc("ra_late", 1, 0, 0, 1, 32'h0BAD_0BAD, 0, 0, 0, 0, 0, 0);
        cyc("ra_after", 1, 0, 0, 0, 32'd0, 0, 0, 0, 0, 0, 0);
        chk_cnt("ra_cnt", 32'd0);

        // Timeout: 4 ACCESS cycles without ready, then sticky ERROR.
        cyc("to_idle", 1, 1, 0, 0, 32'd0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("to_wait", 1, 1, 0, 0, 32'd0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            cyc("to_err", 1, 1, 0, logic'(i % 3 == 0), 32'h5555_0000 + 32'(i), 1, 0, 0, 1, 0, 0);
        cyc("to_rst", 0, 1, 0, 0, 32'd0, 1, 0, 0, 1, 0, 0);
        cyc("to_clear", 1, 0, 0, 0, 32'd0, 0, 0, 0, 0, 0, 0);
        chk_cnt("to_cnt", 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_stall_ctrl.md
Name: dmem_stall_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage against a variable-latency data memory with a ready handshake.
- Holds the F/D/E/M pipeline registers while an access is outstanding.
- Injects a bubble into the MEM/WB register during each held cycle.
- Captures the returned read data for MEM/WB to latch on the release cycle.
- Sits between the EX/MEM register outputs, the data memory port and the hazard/stall network.

Parameters:
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before the ERROR state is entered (1..2^CNT_W-1).
- CNT_W, 8, width of the wait counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets all state.
- MemReadM  in  1  load in MEM stage.
- MemWriteM  in  1  store in MEM stage.
- mem_ready  in  1  data memory completes the current request this cycle.
- mem_rdata  in  32  data memory read data, valid when mem_ready=1.
- mem_req  out  1  request to data memory.
- mem_we  out  1  write enable to data memory.
- StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
- BubbleW  out  1  ORed into the MEM/WB clear; forces RegWriteW=0 and MemtoRegW=0 next edge.
- ReadDataM  out  32  captured load data, presented to MEM/WB.
- MemErr  out  1  sticky timeout flag.
- StallCount  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset values: state=IDLE, counter=0, ReadDataM=0, MemErr=0, StallCount=0, all other outputs 0.
- access = MemReadM | MemWriteM.
- FSM states (package enum): IDLE, ACCESS, DONE, ERROR.
- IDLE:
  - If access=1: stalls and BubbleW are asserted combinationally this cycle; next state is ACCESS; counter clears.
  - If access=0: no outputs asserted.
- ACCESS:
  - mem_req=1, mem_we=MemWriteM; stalls and BubbleW are asserted.
  - If mem_ready=1: ReadDataM<=mem_rdata (loads only; stores leave ReadDataM unchanged); next state is DONE.
  - Else the counter increments. When counter==TIMEOUT_CYCLES-1 and mem_ready=0, next state is ERROR.
  - mem_ready=1 on the timeout cycle takes priority: go to DONE.
- DONE:
  - All stalls, BubbleW and mem_req are 0 regardless of access.
  - The pipeline advances and MEM/WB latches ReadDataM. Next state is IDLE.
- ERROR:
  - Sticky. MemErr=1; all stalls and BubbleW are 1; mem_req=0.
  - Exit only by reset.
- Latency:
  - An access seen in IDLE at cycle T gives ACCESS at T+1.
  - With mem_ready at T+1, state is DONE at T+2.
  - Minimum is 2 stall cycles plus 1 release cycle; each extra memory wait cycle adds 1.
- Back-to-back accesses: the second instruction enters MEM on the DONE→IDLE edge and is detected in IDLE the following cycle. No access is merged or skipped.
- mem_ready outside ACCESS is ignored. MemReadM and MemWriteM both 1 is treated as a store.
- Address and write data are taken by the memory directly from the EX/MEM outputs; these stay stable because StallM is held.
- Reset during ACCESS: state goes to IDLE and mem_req drops on the next cycle. The data memory must tolerate an abandoned request.
- Counter width: CNT_W, wraps never; it is cleared on IDLE→ACCESS.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- When defined: StallCount increments by 1 on every cycle StallM=1 (including ERROR). It saturates at 32'hFFFF_FFFF and resets to 0.
- When undefined: StallCount is tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package mips_mem_pkg holds:
  - the state enum dmem_state_t {IDLE, ACCESS, DONE, ERROR};
  - the default constant DMEM_TIMEOUT=255.
- One natural sub-module: wait_timer. It is a CNT_W counter with clear, enable, and a terminal-count output at TIMEOUT_CYCLES-1; it is instantiated once.

Test Plan:
- Load with memory ready in the first ACCESS cycle, mem_rdata=32'hDEADBEEF:
  - StallM=1 for exactly 2 cycles, then 0 for 1 cycle;
  - ReadDataM=32'hDEADBEEF at DONE; mem_req high for 1 cycle.
- Store with 3 wait cycles (mem_ready on the 4th ACCESS cycle):
  - mem_we=1 for 4 cycles; stall for 5 cycles;
  - BubbleW=1 on every stall cycle; ReadDataM unchanged.
- Two back-to-back loads returning 32'h1 and 32'h2:
  - two distinct DONE cycles, 32'h1 and then 32'h2 presented;
  - one IDLE cycle between DONE and the next ACCESS.
- TIMEOUT_CYCLES=4, mem_ready held 0:
  - ERROR entered after 4 ACCESS cycles; MemErr=1 and stalls stay 1 for 20 further cycles;
  - reset=0 for one edge returns all outputs to 0.
- Reset asserted in the 2nd ACCESS cycle:
  - next cycle state=IDLE, mem_req=0, ReadDataM=0;
  - a late mem_ready=1 pulse is ignored.
- DMEM_PERF_CNT_EN defined, after the store scenario: StallCount=5. Without the macro: StallCount=0.
